vga_rect_fill_master: RTL and testbench



---
 rtl/vga_rect_fill_master_if.sv | 23 ++
 rtl/vga_rect_fill_master.sv | 194 +++++++++++++++++++
 tb/tb_vga_rect_fill_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_fill_master_if.sv
// Shared-bus handshake between the rectangle fill master and the top-level arbiter.
// Carries request/grant, write strobe and address; the tri-state data lines
// stay a plain inout port on the master.
interface vga_rect_fill_master_if;
   logic       BUS_REQ;
   logic       BUS_GNT;
   logic       BUS_WE;
   logic [7:0] BUS_ADDR;

   modport master (
      output BUS_REQ,
      output BUS_WE,
      output BUS_ADDR,
      input  BUS_GNT
   );

   modport slave (
      input  BUS_REQ,
      input  BUS_WE,
      input  BUS_ADDR,
      output BUS_GNT
   );
endinterface

// File: rtl/vga_rect_fill_master.sv
// Rectangle fill bus master for the 160x120 1-bit VGA frame buffer.
// Writes X/Y/data registers at BASE_ADDR..BASE_ADDR+2, one pixel per X write
// once the data register holds the fill value.
// Optional clipping to X_MAX/Y_MAX is built when VGA_RECT_FILL_CLIP_EN is defined.
//
// state | meaning
// IDLE  | waiting for START
// REQ   | bus requested, waiting for grant
// WR_X  | write column register (first pixel setup or next pixel)
// WR_Y  | write row register (first pixel setup or row change)
// WR_D  | write pixel value into the data register (first pixel only)
// STEP  | advance decision, folded into the write transitions (never entered)
// FIN   | one-cycle DONE pulse, bus released
module vga_rect_fill_master #(
   parameter logic [7:0] BASE_ADDR = 8'hB0,
   parameter int         X_MAX     = 159,
   parameter int         Y_MAX     = 119
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          START,
   input  logic [7:0]                    X0,
   input  logic [6:0]                    Y0,
   input  logic [7:0]                    W,
   input  logic [6:0]                    H,
   input  logic                          PIXEL,
   output logic                          BUSY,
   output logic                          DONE,
   inout  wire  [7:0]                    BUS_DATA,
   vga_rect_fill_master_if.master        bus
);

   typedef enum logic [2:0] {IDLE, REQ, WR_X, WR_Y, WR_D, STEP, FIN} state_t;

   state_t     state, state_nxt;
   logic [7:0] x0_lat, w_lat, cur_x, col_cnt;
   logic [6:0] cur_y, row_cnt;
   logic       pix_lat, first;
   logic [7:0] eff_w;
   logic [6:0] eff_h;
   logic       clip_out, zero_cmd;
   logic       we, req;
   logic [7:0] addr, wdata;
   state_t     step_nxt;

`ifdef VGA_RECT_FILL_CLIP_EN
   localparam logic [7:0] X_LAST = 8'(X_MAX);
   localparam logic [6:0] Y_LAST = 7'(Y_MAX);
   logic [7:0] x_room;
   logic [6:0] y_room;
`endif

   // Effective rectangle size at command time (clipped when enabled).
   always_comb begin
`ifdef VGA_RECT_FILL_CLIP_EN
      x_room   = X_LAST - X0 + 8'd1;
      y_room   = Y_LAST - Y0 + 7'd1;
      clip_out = (X0 > X_LAST) || (Y0 > Y_LAST);
      eff_w    = (W > x_room) ? x_room : W;
      eff_h    = (H > y_room) ? y_room : H;
`else
      clip_out = 1'b0;
      eff_w    = W;
      eff_h    = H;
`endif
      zero_cmd = clip_out || (eff_w == 8'd0) || (eff_h == 7'd0);
   end

   // Where to go after a pixel has been drawn: next column, next row, or done.
   always_comb begin
      if (col_cnt != 8'd0)
         step_nxt = WR_X;
      else if (row_cnt != 7'd0)
         step_nxt = WR_Y;
      else
         step_nxt = FIN;
   end

   // Next-state and bus outputs; the write strobe is gated by the live grant.
   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      addr      = 8'h00;
      wdata     = 8'h00;
      case (state)
         IDLE: begin
            if (START)
               state_nxt = zero_cmd ? FIN : REQ;
         end
         REQ: begin
            BUSY = 1'b1;
            req  = 1'b1;
            if (bus.BUS_GNT)
               state_nxt = WR_X;
         end
         WR_X: begin
            BUSY  = 1'b1;
            req   = 1'b1;
            wdata = cur_x;
            if (bus.BUS_GNT) begin
               we        = 1'b1;
               addr      = BASE_ADDR;
               state_nxt = first ? WR_Y : step_nxt;
            end
         end
         WR_Y: begin
            BUSY  = 1'b1;
            req   = 1'b1;
            wdata = {1'b0, cur_y};
            if (bus.BUS_GNT) begin
               we        = 1'b1;
               addr      = BASE_ADDR + 8'd1;
               state_nxt = first ? WR_D : WR_X;
            end
         end
         WR_D: begin
            BUSY  = 1'b1;
            req   = 1'b1;
            wdata = {7'b0, pix_lat};
            if (bus.BUS_GNT) begin
               we        = 1'b1;
               addr      = BASE_ADDR + 8'd2;
               state_nxt = step_nxt;
            end
         end
         FIN: begin
            DONE      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.BUS_REQ  = req;
   assign bus.BUS_WE   = we;
   assign bus.BUS_ADDR = addr;
   assign BUS_DATA     = we ? wdata : 8'hzz;

   // State register plus coordinate and remaining-count updates on accepted writes.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= IDLE;
         x0_lat  <= 8'h00;
         w_lat   <= 8'h00;
         pix_lat <= 1'b0;
         cur_x   <= 8'h00;
         cur_y   <= 7'h00;
         col_cnt <= 8'h00;
         row_cnt <= 7'h00;
         first   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (START) begin
                  x0_lat  <= X0;
                  w_lat   <= eff_w;
                  pix_lat <= PIXEL;
                  cur_x   <= X0;
                  cur_y   <= Y0;
                  col_cnt <= eff_w - 8'd1;
                  row_cnt <= eff_h - 7'd1;
                  first   <= 1'b1;
               end
            end
            WR_X, WR_D: begin
               // WR_X during first-pixel setup draws nothing yet; the pixel lands on WR_D.
               if (bus.BUS_GNT && (state == WR_D || !first)) begin
                  first <= 1'b0;
                  if (col_cnt != 8'd0) begin
                     cur_x   <= cur_x + 8'd1;
                     col_cnt <= col_cnt - 8'd1;
                  end else if (row_cnt != 7'd0) begin
                     cur_y   <= cur_y + 7'd1;
                     row_cnt <= row_cnt - 7'd1;
                  end
               end
            end
            WR_Y: begin
               // Row change: the new row is on the bus, restart at the left column.
               if (bus.BUS_GNT && !first) begin
                  cur_x   <= x0_lat;
                  col_cnt <= w_lat - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed bench for vga_rect_fill_master: table of fill commands checked
// against a row/column write-order model, plus reset-abort and clip sequences.
module tb_vga_rect_fill_master;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       START = 1'b0;
   logic [7:0] X0 = 8'h00;
   logic [6:0] Y0 = 7'h00;
   logic [7:0] W = 8'h00;
   logic [6:0] H = 7'h00;
   logic       PIXEL = 1'b0;
   logic       BUSY, DONE;
   wire  [7:0] BUS_DATA;

   vga_rect_fill_master_if bus_if ();

   vga_rect_fill_master dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .X0       (X0),
      .Y0       (Y0),
      .W        (W),
      .H        (H),
      .PIXEL    (PIXEL),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .BUS_DATA (BUS_DATA),
      .bus      (bus_if.master)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   typedef struct {
      logic [7:0]  x0;
      logic [6:0]  y0;
      logic [7:0]  w;
      logic [6:0]  h;
      logic        pix;
      int          drop_after;
      int          gap;
      bit          poke;
      int          exp_n;
      logic [15:0] exp_last;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected write stream: first row sets X, Y, data; later rows set Y then sweep X.
   task automatic build_exp(input logic [7:0] x0, input logic [6:0] y0,
                            input logic [7:0] w, input logic [6:0] h, input logic pix);
      logic [6:0] yv;
      logic [7:0] xv;
      exp_q.delete();
      if (w == 8'd0 || h == 7'd0) return;
      for (int r = 0; r < int'(h); r++) begin
         yv = y0 + 7'(r);
         if (r == 0) begin
            exp_q.push_back({8'hB0, x0});
            exp_q.push_back({8'hB1, 1'b0, yv});
            exp_q.push_back({8'hB2, 7'b0, pix});
         end else begin
            exp_q.push_back({8'hB1, 1'b0, yv});
            exp_q.push_back({8'hB0, x0});
         end
         for (int c = 1; c < int'(w); c++) begin
            xv = x0 + 8'(c);
            exp_q.push_back({8'hB0, xv});
         end
      end
   endtask

   task automatic run_cmd(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] w,
                          input logic [6:0] h, input logic pix, input int drop_after,
                          input int gap, input bit poke, input string tag);
      int  cyc, last_wr, done_cyc, gap_left;
      bit  dropped, req_seen;
      got_q.delete();
      @(negedge CLK);
      X0 = x0; Y0 = y0; W = w; H = h; PIXEL = pix; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      cyc = 0; last_wr = -1; done_cyc = -1; gap_left = 0;
      dropped = 1'b0; req_seen = 1'b0;
      while (cyc < 3000) begin
         if (bus_if.BUS_REQ) req_seen = 1'b1;
         if (cyc == 0 && exp_q.size() > 0) chk({tag, "_busy"}, int'(BUSY), 1);
         if (gap_left > 0) begin
            chk({tag, "_gap_we"}, int'(bus_if.BUS_WE), 0);
            chk({tag, "_gap_addr"}, int'(bus_if.BUS_ADDR), 0);
            gap_left--;
            if (gap_left == 0) bus_if.BUS_GNT = 1'b1;
         end
         if (bus_if.BUS_WE) begin
            got_q.push_back({bus_if.BUS_ADDR, BUS_DATA});
            last_wr = cyc;
            if (!dropped && drop_after > 0 && got_q.size() == drop_after) begin
               dropped = 1'b1;
               bus_if.BUS_GNT = 1'b0;
               gap_left = gap;
            end
         end
         if (DONE) begin
            done_cyc = cyc;
            chk({tag, "_req_at_done"}, int'(bus_if.BUS_REQ), 0);
            chk({tag, "_busy_at_done"}, int'(BUSY), 0);
            break;
         end
         if (poke && cyc == 2) begin
            START = 1'b1; X0 = 8'h63; W = 8'd1;
         end
         if (poke && cyc == 3) START = 1'b0;
         @(negedge CLK);
         cyc++;
      end
      bus_if.BUS_GNT = 1'b1;
      START = 1'b0;
      chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
      chk({tag, "_n_writes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_write%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
      if (exp_q.size() > 0)
         chk({tag, "_done_latency"}, done_cyc, last_wr + 1);
      else begin
         chk({tag, "_done_latency"}, done_cyc, 0);
         chk({tag, "_no_req"}, int'(req_seen), 0);
      end
      @(negedge CLK);
      chk({tag, "_done_pulse"}, int'(DONE), 0);
   endtask

   initial begin
      bus_if.BUS_GNT = 1'b1;
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_req", int'(bus_if.BUS_REQ), 0);
      chk("rst_we", int'(bus_if.BUS_WE), 0);
      chk("rst_addr", int'(bus_if.BUS_ADDR), 0);
      RESET = 1'b1;
      @(negedge CLK);

`ifndef VGA_RECT_FILL_CLIP_EN
      vecs.push_back('{8'd10,  7'd20,  8'd1, 7'd1, 1'b1, -1, 0, 1'b0, 3,  16'hB201});
      vecs.push_back('{8'd5,   7'd7,   8'd3, 7'd2, 1'b1, -1, 0, 1'b1, 9,  16'hB007});
      vecs.push_back('{8'd5,   7'd7,   8'd3, 7'd2, 1'b1,  4, 4, 1'b0, 9,  16'hB007});
      vecs.push_back('{8'd0,   7'd0,   8'd4, 7'd2, 1'b0, -1, 0, 1'b0, 11, 16'hB003});
      vecs.push_back('{8'd254, 7'd3,   8'd3, 7'd1, 1'b1, -1, 0, 1'b0, 5,  16'hB000});
      vecs.push_back('{8'd3,   7'd126, 8'd1, 7'd3, 1'b1, -1, 0, 1'b0, 7,  16'hB003});
`endif
      vecs.push_back('{8'd9,   7'd9,   8'd0, 7'd5, 1'b1, -1, 0, 1'b0, 0,  16'h0000});
      vecs.push_back('{8'd9,   7'd9,   8'd5, 7'd0, 1'b1, -1, 0, 1'b0, 0,  16'h0000});

      for (int v = 0; v < vecs.size(); v++) begin
         build_exp(vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].pix);
         run_cmd(vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].pix,
                 vecs[v].drop_after, vecs[v].gap, vecs[v].poke, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_n);
         if (vecs[v].exp_n > 0 && got_q.size() > 0)
            chk($sformatf("vec%0d_last", v), int'(got_q[got_q.size()-1]), int'(vecs[v].exp_last));
      end

      // Reset in the middle of an 8x8 fill aborts immediately.
      @(negedge CLK);
      X0 = 8'd20; Y0 = 7'd20; W = 8'd8; H = 7'd8; PIXEL = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (10) @(negedge CLK);
      chk("abort_busy_before", int'(BUSY), 1);
      RESET = 1'b0;
      @(negedge CLK);
      chk("abort_we", int'(bus_if.BUS_WE), 0);
      chk("abort_req", int'(bus_if.BUS_REQ), 0);
      chk("abort_busy", int'(BUSY), 0);
      chk("abort_done", int'(DONE), 0);
      RESET = 1'b1;
      begin
         int stray = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (bus_if.BUS_WE || DONE || bus_if.BUS_REQ) stray++;
         end
         chk("abort_quiet", stray, 0);
      end
      build_exp(8'd10, 7'd20, 8'd1, 7'd1, 1'b1);
      run_cmd(8'd10, 7'd20, 8'd1, 7'd1, 1'b1, -1, 0, 1'b0, "post_abort");

`ifdef VGA_RECT_FILL_CLIP_EN
      exp_q.delete();
      exp_q.push_back(16'hB09E);
      exp_q.push_back(16'hB177);
      exp_q.push_back(16'hB201);
      exp_q.push_back(16'hB09F);
      run_cmd(8'd158, 7'd119, 8'd5, 7'd3, 1'b1, -1, 0, 1'b0, "clip_edge");
      exp_q.delete();
      run_cmd(8'd200, 7'd10, 8'd4, 7'd4, 1'b1, -1, 0, 1'b0, "clip_out");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
